ocx_tlx_credit_tx_cntlr: RTL and testbench

//  Transmit-side credit manager for a remote receive FIFO (FIFO_ADDR_WIDTH-sized buffer on far end of the link).

---
 rtl/ocx_tlx_credit_pkg.sv | 16 +
 rtl/ocx_tlx_credit_err_latch.sv | 25 ++
 rtl/ocx_tlx_credit_tx_cntlr.sv | 110 +++++++++++
 tb/tb_ocx_tlx_credit_tx_cntlr.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/ocx_tlx_credit_pkg.sv
// Shared definitions for the TLX transmit and receive credit blocks.
// Holds the credit FSM state encoding and the default credit widths.
package ocx_tlx_credit_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'b00,
    StLoad    = 2'b01,
    StActive  = 2'b10,
    StQuiesce = 2'b11
  } credit_state_e;

  localparam int unsigned CreditWidthDef = 5;
  localparam int unsigned InitCreditsDef = 16;
  localparam int unsigned RetWidthDef    = 3;

endpackage

// File: rtl/ocx_tlx_credit_err_latch.sv
// Pulse-to-sticky error capture: a set pulse is held until reset or clear.
// Clear wins over a coincident set.
module ocx_tlx_credit_err_latch (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic set_i,
  output logic err_o
);

  logic err_q, err_d;

  always_comb begin
    err_d = err_q | set_i;
    if (clr_i) err_d = 1'b0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign err_o = err_q;

endmodule

// File: rtl/ocx_tlx_credit_tx_cntlr.sv
// Transmit-side credit manager guarding a remote receive FIFO against overflow.
// Define OCX_TLX_CREDIT_ERR_STICKY_EN to make the error outputs sticky (cleared by credit_init).
module ocx_tlx_credit_tx_cntlr
  import ocx_tlx_credit_pkg::*;
#(
  parameter int unsigned CREDIT_WIDTH = CreditWidthDef,
  parameter int unsigned INIT_CREDITS = InitCreditsDef,
  parameter int unsigned RET_WIDTH    = RetWidthDef
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    credit_init,
  input  logic                    tx_send,
  input  logic                    credit_return_valid,
  input  logic [RET_WIDTH-1:0]    credit_return_cnt,
  output logic                    tx_credit_ok,
  output logic                    tx_credit_look_ahead,
  output logic [CREDIT_WIDTH-1:0] credit_count,
  output logic                    credit_all_returned,
  output logic                    credit_underflow_error,
  output logic                    credit_overflow_error
);

  localparam int unsigned SumW = CREDIT_WIDTH + 1;
  localparam logic [CREDIT_WIDTH-1:0] InitCount = CREDIT_WIDTH'(INIT_CREDITS);
  localparam logic [SumW-1:0]         InitSum   = SumW'(INIT_CREDITS);

  credit_state_e           state_q, state_d;
  logic [CREDIT_WIDTH-1:0] count_q, count_d;
  logic [SumW-1:0]         ret_add, sum;
  logic                    send_ok, udf_evt, ovf_evt;

  assign tx_credit_ok = (state_q == StActive) && (count_q != '0);
  assign send_ok      = tx_send & tx_credit_ok;
  assign udf_evt      = tx_send & ~tx_credit_ok;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    ovf_evt = 1'b0;
    ret_add = '0;
    sum     = '0;
    unique case (state_q)
      StIdle: begin
        state_d = StLoad;
        ovf_evt = credit_return_valid;
      end
      StLoad: begin
        state_d = StActive;
        count_d = InitCount;
        ovf_evt = credit_return_valid;
      end
      StActive: begin
        if (credit_init) state_d = StQuiesce;
      end
      StQuiesce: begin
        // Leave quiesce only once every credit is back, judged on the registered count.
        if (count_q == InitCount) state_d = StActive;
      end
      default: state_d = StIdle;
    endcase

    if ((state_q == StActive) || (state_q == StQuiesce)) begin
      ret_add = credit_return_valid ? SumW'(credit_return_cnt) : '0;
      sum     = {1'b0, count_q} + ret_add - SumW'(send_ok);
      if (sum > InitSum) begin
        count_d = InitCount;
        ovf_evt = 1'b1;
      end else begin
        count_d = sum[CREDIT_WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  assign tx_credit_look_ahead = (state_d == StActive) && (count_d != '0);
  assign credit_count         = count_q;
  assign credit_all_returned  = (count_q == InitCount);

`ifdef OCX_TLX_CREDIT_ERR_STICKY_EN
  ocx_tlx_credit_err_latch u_udf_latch (
    .clk_i (clock),
    .rst_i (reset),
    .clr_i (credit_init),
    .set_i (udf_evt),
    .err_o (credit_underflow_error)
  );

  ocx_tlx_credit_err_latch u_ovf_latch (
    .clk_i (clock),
    .rst_i (reset),
    .clr_i (credit_init),
    .set_i (ovf_evt),
    .err_o (credit_overflow_error)
  );
`else
  assign credit_underflow_error = udf_evt;
  assign credit_overflow_error  = ovf_evt;
`endif

endmodule

// File: tb/tb_ocx_tlx_credit_tx_cntlr.sv
// Randomized bench for ocx_tlx_credit_tx_cntlr against an integer credit model.
// Honours OCX_TLX_CREDIT_ERR_STICKY_EN when built with it.
module tb_ocx_tlx_credit_tx_cntlr;

  localparam int CW = 5;
  localparam int IC = 16;
  localparam int RW = 3;

  // Model phases
  localparam int PIdle = 0, PLoad = 1, PRun = 2, PDrain = 3;

  logic          clock = 1'b0;
  logic          reset;
  logic          credit_init;
  logic          tx_send;
  logic          credit_return_valid;
  logic [RW-1:0] credit_return_cnt;
  logic          tx_credit_ok;
  logic          tx_credit_look_ahead;
  logic [CW-1:0] credit_count;
  logic          credit_all_returned;
  logic          credit_underflow_error;
  logic          credit_overflow_error;

  ocx_tlx_credit_tx_cntlr #(
    .CREDIT_WIDTH (CW),
    .INIT_CREDITS (IC),
    .RET_WIDTH    (RW)
  ) dut (
    .clock                  (clock),
    .reset                  (reset),
    .credit_init            (credit_init),
    .tx_send                (tx_send),
    .credit_return_valid    (credit_return_valid),
    .credit_return_cnt      (credit_return_cnt),
    .tx_credit_ok           (tx_credit_ok),
    .tx_credit_look_ahead   (tx_credit_look_ahead),
    .credit_count           (credit_count),
    .credit_all_returned    (credit_all_returned),
    .credit_underflow_error (credit_underflow_error),
    .credit_overflow_error  (credit_overflow_error)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state and its next values
  int m_cnt, m_ph, n_cnt, n_ph;
  bit m_uf_s, m_of_s, n_uf_s, n_of_s;
  bit e_ok, e_la, e_uf, e_of;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, got, exp);
    end
  endtask

  task automatic model_eval();
    int  t;
    bit  uf, of;
    e_ok = (m_ph == PRun) && (m_cnt > 0);
    uf   = tx_send && !e_ok;
    of   = 1'b0;
    n_cnt = m_cnt;
    case (m_ph)
      PIdle: begin n_ph = PLoad; of = credit_return_valid; end
      PLoad: begin n_ph = PRun; n_cnt = IC; of = credit_return_valid; end
      PRun:  n_ph = credit_init ? PDrain : PRun;
      default: n_ph = (m_cnt == IC) ? PRun : PDrain;
    endcase
    if (m_ph == PRun || m_ph == PDrain) begin
      t = m_cnt + (credit_return_valid ? int'(credit_return_cnt) : 0) - ((tx_send && e_ok) ? 1 : 0);
      if (t > IC) begin
        t  = IC;
        of = 1'b1;
      end
      n_cnt = t;
    end
    e_la = (n_ph == PRun) && (n_cnt != 0);
`ifdef OCX_TLX_CREDIT_ERR_STICKY_EN
    e_uf   = m_uf_s;
    e_of   = m_of_s;
    n_uf_s = credit_init ? 1'b0 : (m_uf_s | uf);
    n_of_s = credit_init ? 1'b0 : (m_of_s | of);
`else
    e_uf   = uf;
    e_of   = of;
    n_uf_s = 1'b0;
    n_of_s = 1'b0;
`endif
  endtask

  task automatic check_outputs();
    model_eval();
    check_eq("tx_credit_ok", int'(tx_credit_ok), int'(e_ok));
    check_eq("look_ahead", int'(tx_credit_look_ahead), int'(e_la));
    check_eq("credit_count", int'(credit_count), m_cnt);
    check_eq("all_returned", int'(credit_all_returned), (m_cnt == IC) ? 1 : 0);
    check_eq("underflow_err", int'(credit_underflow_error), int'(e_uf));
    check_eq("overflow_err", int'(credit_overflow_error), int'(e_of));
  endtask

  // Called at posedge+1: drive, settle, check, advance one clock.
  task automatic cycle(input bit s, input bit rv, input int rc, input bit ini);
    tx_send             = s;
    credit_return_valid = rv;
    credit_return_cnt   = RW'(rc);
    credit_init         = ini;
    #2;
    check_outputs();
    @(posedge clock);
    #1;
    m_cnt  = n_cnt;
    m_ph   = n_ph;
    m_uf_s = n_uf_s;
    m_of_s = n_of_s;
  endtask

  task automatic apply_reset();
    tx_send             = 1'b0;
    credit_return_valid = 1'b0;
    credit_return_cnt   = '0;
    credit_init         = 1'b0;
    reset               = 1'b1;
    #1;
    m_cnt  = 0;
    m_ph   = PIdle;
    m_uf_s = 1'b0;
    m_of_s = 1'b0;
    check_outputs();
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    @(posedge clock);
    #1;
    apply_reset();

    // Bring-up with no traffic
    repeat (4) cycle(0, 0, 0, 0);
    // Drain all credits, then one extra send
    repeat (IC + 1) cycle(1, 0, 0, 0);
    // Return at zero credit
    cycle(0, 1, 3, 0);
    cycle(0, 1, 2, 0);
    // Simultaneous send and return at count 5
    cycle(1, 1, 2, 0);
    cycle(0, 1, 7, 0);
    cycle(0, 1, 2, 0);
    // Saturation from 15
    cycle(0, 1, 3, 0);
    cycle(0, 0, 0, 0);
    repeat (6) cycle(1, 0, 0, 0);
    // Quiesce at count 10, send refused, refill, return to active
    cycle(0, 0, 0, 1);
    cycle(1, 0, 0, 0);
    cycle(0, 1, 6, 0);
    cycle(0, 0, 0, 0);
    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 1);
    // Returns during bring-up are discarded and flagged
    repeat (3) cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 1);
    cycle(0, 1, 1, 0);
    apply_reset();
    cycle(0, 1, 4, 0);
    cycle(0, 1, 5, 1);
    cycle(0, 0, 0, 0);

    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        apply_reset();
      end else begin
        cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0),
              int'($urandom_range(0, 7)), ($urandom_range(0, 39) == 0));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
